// File: rtl/pixel_mask_unit.sv
// rtl/pixel_mask_unit.sv - streaming window/threshold pixel mask stage; optional MASK_STATS_EN adds kept_cnt
module pixel_mask_unit #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter logic [PIX_W-1:0] MASK_VALUE = '0,
    localparam int XW = $clog2(IMG_W),
    localparam int YW = $clog2(IMG_H),
    localparam int KW = $clog2(IMG_W*IMG_H+1)
) (
    input  logic             clk_mask,
    input  logic             rst_n,
    input  logic             start,
    input  logic [XW-1:0]    win_x0,
    input  logic [XW-1:0]    win_x1,
    input  logic [YW-1:0]    win_y0,
    input  logic [YW-1:0]    win_y1,
    input  logic [PIX_W-1:0] thresh,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_pix,
    output logic             in_ready,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_pix,
    output logic             out_eol,
    output logic             out_eof,
    input  logic             out_ready,
    output logic             busy,
`ifdef MASK_STATS_EN
    output logic [KW-1:0]    kept_cnt,
`endif
    output logic             done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    logic [1:0]       state;
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
    logic [XW-1:0]    cfg_x0;
    logic [XW-1:0]    cfg_x1;
    logic [YW-1:0]    cfg_y0;
    logic [YW-1:0]    cfg_y1;
    logic [PIX_W-1:0] cfg_thr;

    logic in_acc;
    logic out_acc;
    logic start_acc;
    logic at_eol;
    logic at_eof;
    logic keep;

    assign busy      = (state != ST_IDLE);
    assign in_ready  = (state == ST_RUN) && (!out_valid || out_ready);
    assign in_acc    = in_valid && in_ready;
    assign out_acc   = out_valid && out_ready;
    assign start_acc = start && (state == ST_IDLE);
    assign at_eol    = (x == X_LAST);
    assign at_eof    = at_eol && (y == Y_LAST);
    // An inverted window (x0>x1 or y0>y1) can never satisfy both bounds, so it masks everything.
    assign keep      = (x >= cfg_x0) && (x <= cfg_x1) &&
                       (y >= cfg_y0) && (y <= cfg_y1) &&
                       (in_pix >= cfg_thr);

    // Frame sequencing: arm on start, drain after the last input pixel, idle once the eof beat leaves.
    always_ff @(posedge clk_mask or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start)              state <= ST_RUN;
                ST_RUN:   if (in_acc && at_eof)   state <= ST_DRAIN;
                ST_DRAIN: if (out_acc && out_eof) state <= ST_IDLE;
                default:                          state <= ST_IDLE;
            endcase
        end
    end

    // Window and threshold are captured only when a start is accepted, frozen for the whole frame.
    always_ff @(posedge clk_mask or negedge rst_n) begin
        if (!rst_n) begin
            cfg_x0  <= '0;
            cfg_x1  <= '0;
            cfg_y0  <= '0;
            cfg_y1  <= '0;
            cfg_thr <= '0;
        end else if (start_acc) begin
            cfg_x0  <= win_x0;
            cfg_x1  <= win_x1;
            cfg_y0  <= win_y0;
            cfg_y1  <= win_y1;
            cfg_thr <= thresh;
        end
    end

    // Raster position of the next input pixel; advances only on an accepted pixel.
    always_ff @(posedge clk_mask or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (start_acc) begin
            x <= '0;
            y <= '0;
        end else if (in_acc) begin
            if (at_eol) begin
                x <= '0;
                y <= at_eof ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    // Single output register: loads on input accept, empties on output accept, otherwise holds.
    always_ff @(posedge clk_mask or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pix   <= '0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else if (in_acc) begin
            out_valid <= 1'b1;
            out_pix   <= keep ? in_pix : MASK_VALUE;
            out_eol   <= at_eol;
            out_eof   <= at_eof;
        end else if (out_acc) begin
            out_valid <= 1'b0;
        end
    end

    // Done pulses the cycle after the eof beat is taken by the consumer.
    always_ff @(posedge clk_mask or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else begin
            done <= (state == ST_DRAIN) && out_acc && out_eof;
        end
    end

`ifdef MASK_STATS_EN
    // Count of pixels that passed the mask in the current (or last completed) frame.
    always_ff @(posedge clk_mask or negedge rst_n) begin
        if (!rst_n) begin
            kept_cnt <= '0;
        end else if (start_acc) begin
            kept_cnt <= '0;
        end else if (in_acc && keep) begin
            kept_cnt <= kept_cnt + KW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pixel_mask_unit.sv
// tb/tb_pixel_mask_unit.sv - self-checking bench for pixel_mask_unit (4x4 image, random handshakes)
module tb_pixel_mask_unit;

    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    logic       clk_mask = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] win_x0 = '0, win_x1 = '0, win_y0 = '0, win_y1 = '0;
    logic [7:0] thresh = '0;
    logic       in_valid = 1'b0;
    logic [7:0] in_pix = '0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_pix;
    logic       out_eol;
    logic       out_eof;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       done;
`ifdef MASK_STATS_EN
    logic [4:0] kept_cnt;
`endif

    pixel_mask_unit #(.PIX_W(8), .IMG_W(W), .IMG_H(H), .MASK_VALUE(8'h00)) dut (
        .clk_mask(clk_mask), .rst_n(rst_n), .start(start),
        .win_x0(win_x0), .win_x1(win_x1), .win_y0(win_y0), .win_y1(win_y1),
        .thresh(thresh), .in_valid(in_valid), .in_pix(in_pix), .in_ready(in_ready),
        .out_valid(out_valid), .out_pix(out_pix), .out_eol(out_eol), .out_eof(out_eof),
        .out_ready(out_ready), .busy(busy),
`ifdef MASK_STATS_EN
        .kept_cnt(kept_cnt),
`endif
        .done(done)
    );

    always #5 clk_mask = ~clk_mask;

    int total = 0;
    int bad = 0;

    logic [7:0] pix_in [N];
    int m_x0, m_x1, m_y0, m_y1, m_thr;

    logic [7:0] got_pix [$];
    bit         got_eol [$];
    bit         got_eof [$];
    int eof_cyc, done_cyc, ready_viol, busy_drop, timeout, busy_at_done;

    function automatic logic [7:0] exp_pix(int i);
        int xx = i % W;
        int yy = i / W;
        if (xx >= m_x0 && xx <= m_x1 && yy >= m_y0 && yy <= m_y1 && int'(pix_in[i]) >= m_thr)
            return pix_in[i];
        return 8'h00;
    endfunction

    function automatic int exp_kept();
        int k = 0;
        for (int i = 0; i < N; i++)
            if (exp_pix(i) == pix_in[i] && (i % W) >= m_x0 && (i % W) <= m_x1 &&
                (i / W) >= m_y0 && (i / W) <= m_y1 && int'(pix_in[i]) >= m_thr) k++;
        return k;
    endfunction

    task automatic set_cfg(input int x0, input int x1, input int y0, input int y1, input int thr);
        m_x0 = x0; m_x1 = x1; m_y0 = y0; m_y1 = y1; m_thr = thr;
        win_x0 = 2'(x0); win_x1 = 2'(x1); win_y0 = 2'(y0); win_y1 = 2'(y1); thresh = 8'(thr);
    endtask

    // Called at posedge+1; returns at posedge+1 after done is observed (or timeout).
    task automatic stream_frame(input bit rnd, input bit poke);
        int sent = 0;
        int cyc = 0;
        bit fin = 0;
        got_pix.delete(); got_eol.delete(); got_eof.delete();
        eof_cyc = -1; done_cyc = -1; ready_viol = 0; busy_drop = 0; timeout = 0; busy_at_done = -1;
        start = 1'b1;
        @(posedge clk_mask); #1;
        start = 1'b0;
        while (!fin) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid  = (sent < N) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
            in_pix    = (sent < N) ? pix_in[sent] : 8'h00;
            start     = 1'b0;
            if (poke) begin
                win_x0 = 2'($urandom_range(0, 3)); win_x1 = 2'($urandom_range(0, 3));
                win_y0 = 2'($urandom_range(0, 3)); win_y1 = 2'($urandom_range(0, 3));
                thresh = 8'($urandom_range(0, 255));
                start  = ($urandom_range(0, 2) == 0);
            end
            #1;
            if (done) begin
                done_cyc = cyc; busy_at_done = int'(busy); fin = 1; start = 1'b0;
            end else if (!busy) begin
                busy_drop++;
            end
            if (out_valid && !out_ready && in_ready) ready_viol++;
            if (out_valid && out_ready) begin
                got_pix.push_back(out_pix); got_eol.push_back(out_eol); got_eof.push_back(out_eof);
                if (out_eof) begin
                    eof_cyc = cyc;
                    if (poke) start = 1'b1;
                end
            end
            if (in_valid && in_ready) sent++;
            cyc++;
            if (cyc > 600) begin timeout = 1; fin = 1; end
            @(posedge clk_mask); #1;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk_mask);
        #1;
        total++;
        if ({out_valid, out_pix, out_eol, out_eof, busy, done, in_ready} !== 14'h0) begin
            bad++;
            $display("FAIL reset_outputs got v=%b pix=%h eol=%b eof=%b busy=%b done=%b rdy=%b want all 0",
                     out_valid, out_pix, out_eol, out_eof, busy, done, in_ready);
        end
`ifdef MASK_STATS_EN
        total++;
        if (kept_cnt !== 5'd0) begin bad++; $display("FAIL reset_kept got %0d want 0", kept_cnt); end
`endif
        rst_n = 1'b1;
        @(posedge clk_mask); #1;
    endtask

    task automatic test_frame_basic;
        set_cfg(1, 2, 1, 2, 0);
        for (int i = 0; i < N; i++) pix_in[i] = 8'h10;
        stream_frame(0, 0);
        total++;
        if (timeout != 0 || got_pix.size() != N) begin
            bad++; $display("FAIL basic_len got %0d beats timeout=%0d want %0d", got_pix.size(), timeout, N);
        end
        for (int i = 0; i < N && i < got_pix.size(); i++) begin
            total++;
            if (got_pix[i] !== exp_pix(i) || got_eol[i] !== (i % W == W - 1) || got_eof[i] !== (i == N - 1)) begin
                bad++;
                $display("FAIL basic_beat%0d got pix=%h eol=%b eof=%b want pix=%h eol=%b eof=%b", i,
                         got_pix[i], got_eol[i], got_eof[i], exp_pix(i), (i % W == W - 1), (i == N - 1));
            end
        end
        total++;
        if (done_cyc != eof_cyc + 1 || eof_cyc < 0) begin
            bad++; $display("FAIL basic_done got done@%0d eof@%0d want done one cycle after eof", done_cyc, eof_cyc);
        end
    endtask

    task automatic test_threshold;
        set_cfg(0, 3, 0, 3, 8'h80);
        for (int i = 0; i < N; i++) pix_in[i] = (i % 2 == 1) ? 8'h80 : 8'h7F;
        stream_frame(0, 0);
        total++;
        if (timeout != 0 || got_pix.size() != N) begin
            bad++; $display("FAIL thr_len got %0d beats timeout=%0d want %0d", got_pix.size(), timeout, N);
        end
        for (int i = 0; i < N && i < got_pix.size(); i++) begin
            total++;
            if (got_pix[i] !== exp_pix(i) || got_eol[i] !== (i % W == W - 1) || got_eof[i] !== (i == N - 1)) begin
                bad++;
                $display("FAIL thr_beat%0d got pix=%h eol=%b eof=%b want pix=%h", i,
                         got_pix[i], got_eol[i], got_eof[i], exp_pix(i));
            end
        end
    endtask

    task automatic test_back_to_back;
        for (int f = 0; f < 6; f++) begin
            if (f < 2) begin
                set_cfg(1, 2, 1, 2, 0);
                for (int i = 0; i < N; i++) pix_in[i] = 8'h10;
            end else begin
                if (f == 2) set_cfg(3, 1, 0, 3, 0);
                else if (f == 3) set_cfg(0, 3, 2, 1, 0);
                else set_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                             $urandom_range(0, 3), $urandom_range(0, 255));
                for (int i = 0; i < N; i++) pix_in[i] = 8'($urandom_range(1, 255));
            end
            stream_frame(1, 0);
            total++;
            if (timeout != 0 || got_pix.size() != N || ready_viol != 0) begin
                bad++;
                $display("FAIL bp%0d_len got %0d beats timeout=%0d ready_viol=%0d want %0d beats, 0 viol",
                         f, got_pix.size(), timeout, ready_viol, N);
            end
            for (int i = 0; i < N && i < got_pix.size(); i++) begin
                total++;
                if (got_pix[i] !== exp_pix(i) || got_eol[i] !== (i % W == W - 1) || got_eof[i] !== (i == N - 1)) begin
                    bad++;
                    $display("FAIL bp%0d_beat%0d got pix=%h eol=%b eof=%b want pix=%h eol=%b eof=%b", f, i,
                             got_pix[i], got_eol[i], got_eof[i], exp_pix(i), (i % W == W - 1), (i == N - 1));
                end
            end
            total++;
            if (done_cyc != eof_cyc + 1 || eof_cyc < 0) begin
                bad++; $display("FAIL bp%0d_done got done@%0d eof@%0d", f, done_cyc, eof_cyc);
            end
        end
    endtask

    task automatic test_start_ignored;
        set_cfg(1, 2, 1, 2, 8'h40);
        for (int i = 0; i < N; i++) pix_in[i] = 8'($urandom_range(0, 255));
        stream_frame(1, 1);
        total++;
        if (timeout != 0 || got_pix.size() != N || busy_drop != 0 || busy_at_done != 0) begin
            bad++;
            $display("FAIL start_ign_flow got beats=%0d timeout=%0d busy_drop=%0d busy_at_done=%0d want %0d,0,0,0",
                     got_pix.size(), timeout, busy_drop, busy_at_done, N);
        end
        for (int i = 0; i < N && i < got_pix.size(); i++) begin
            total++;
            if (got_pix[i] !== exp_pix(i)) begin
                bad++; $display("FAIL start_ign_beat%0d got pix=%h want %h", i, got_pix[i], exp_pix(i));
            end
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL start_ign_after got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_midframe;
        set_cfg(1, 2, 1, 2, 0);
        for (int i = 0; i < N; i++) pix_in[i] = 8'h10 + 8'(i);
        start = 1'b1;
        @(posedge clk_mask); #1;
        start = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_pix = pix_in[i]; in_valid = 1'b1;
            @(posedge clk_mask); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, out_pix, out_eol, out_eof, busy, done, in_ready} !== 14'h0) begin
            bad++;
            $display("FAIL midreset_outputs got v=%b pix=%h eol=%b eof=%b busy=%b done=%b rdy=%b want all 0",
                     out_valid, out_pix, out_eol, out_eof, busy, done, in_ready);
        end
        @(posedge clk_mask); #1;
        rst_n = 1'b1;
        @(posedge clk_mask); #1;
        stream_frame(0, 0);
        total++;
        if (timeout != 0 || got_pix.size() != N) begin
            bad++; $display("FAIL midreset_len got %0d beats timeout=%0d want %0d", got_pix.size(), timeout, N);
        end
        for (int i = 0; i < N && i < got_pix.size(); i++) begin
            total++;
            if (got_pix[i] !== exp_pix(i) || got_eol[i] !== (i % W == W - 1) || got_eof[i] !== (i == N - 1)) begin
                bad++;
                $display("FAIL midreset_beat%0d got pix=%h eol=%b eof=%b want pix=%h eol=%b eof=%b", i,
                         got_pix[i], got_eol[i], got_eof[i], exp_pix(i), (i % W == W - 1), (i == N - 1));
            end
        end
    endtask

    task automatic test_stats;
`ifdef MASK_STATS_EN
        set_cfg(1, 2, 1, 2, 0);
        for (int i = 0; i < N; i++) pix_in[i] = 8'h10;
        stream_frame(0, 0);
        total++;
        if (int'(kept_cnt) != exp_kept()) begin
            bad++; $display("FAIL stats_kept got %0d want %0d", kept_cnt, exp_kept());
        end
        start = 1'b1;
        @(posedge clk_mask); #1;
        start = 1'b0;
        total++;
        if (kept_cnt !== 5'd0) begin
            bad++; $display("FAIL stats_clear got %0d want 0", kept_cnt);
        end
        rst_n = 1'b0;
        @(posedge clk_mask); #1;
        rst_n = 1'b1;
        @(posedge clk_mask); #1;
`endif
    endtask

    initial begin
        test_reset();
        test_frame_basic();
        test_threshold();
        test_back_to_back();
        test_start_ignored();
        test_reset_midframe();
        test_stats();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
